// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//    Hazard unit for a five-stage pipeline that also has a multi-cycle ALU
//    operation (modular multiply) in execute. It produces stall, flush and
//    forwarding controls, and counts the cycles in which fetch is stalled.
//
// Ports
//    clk                     sole clock, rising edge
//    rst                     asynchronous reset, active low
//    RA1D, RA2D              decode-stage source registers
//    RA1E, RA2E              execute-stage source registers
//    WA3E, WA3M, WA3W        destination registers in E, M and W
//    RegWriteE/M/W           register-write enables in E, M and W
//    MemtoRegE               instruction in execute is a load
//    PCSrcE                  taken branch / PC write resolved in execute
//    mc_startE, mc_done      multi-cycle op entering execute / completing
//    StallF, StallD, StallE  hold enables for the IF, IF/ID and ID/EX registers
//    FlushD, FlushE          synchronous clears for the IF/ID and ID/EX registers
//    ForwardAE, ForwardBE    operand source: 00 regfile, 01 from W, 10 from M
//    stall_cycles            saturating count of cycles with StallF high
//
// Build option
//    HAZARD_FWD_EN  defined: M/W forwarding; only load-use stalls.
//                   undefined: forwarding tied to 00; any RAW against E or M
//                   stalls decode.
//    W-stage matches never stall: the register file is write-first.

module pipeline_hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  RA1D,
   input  logic [3:0]  RA2D,
   input  logic [3:0]  RA1E,
   input  logic [3:0]  RA2E,
   input  logic [3:0]  WA3E,
   input  logic [3:0]  WA3M,
   input  logic [3:0]  WA3W,
   input  logic        RegWriteE,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic        MemtoRegE,
   input  logic        PCSrcE,
   input  logic        mc_startE,
   input  logic        mc_done,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        FlushD,
   output logic        FlushE,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic [15:0] stall_cycles
);

   typedef enum logic {RUN, MCBUSY} state_t;

   state_t state, state_nxt;
   logic   raw_hazard;

   // ------------------------------------------------------------------
   // Decode-stage RAW detection and forwarding select
   // ------------------------------------------------------------------
`ifdef HAZARD_FWD_EN
   // With forwarding only a load in execute cannot supply its result in time.
   always_comb begin
      raw_hazard = MemtoRegE && RegWriteE && ((RA1D == WA3E) || (RA2D == WA3E));
   end

   function automatic logic [1:0] fwd_sel(
      input logic [3:0] ra,
      input logic [3:0] wa_m,
      input logic [3:0] wa_w,
      input logic       we_m,
      input logic       we_w
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (we_m && (ra == wa_m))
         sel = 2'b10;
      else if (we_w && (ra == wa_w))
         sel = 2'b01;
      return sel;
   endfunction

   always_comb begin
      ForwardAE = '0;
      ForwardBE = '0;
      if (rst) begin
         ForwardAE = fwd_sel(RA1E, WA3M, WA3W, RegWriteM, RegWriteW);
         ForwardBE = fwd_sel(RA2E, WA3M, WA3W, RegWriteM, RegWriteW);
      end
   end
`else
   // Without forwarding any producer still in E or M must retire first.
   always_comb begin
      raw_hazard = (RegWriteE && ((RA1D == WA3E) || (RA2D == WA3E))) ||
                   (RegWriteM && ((RA1D == WA3M) || (RA2D == WA3M)));
   end

   always_comb begin
      ForwardAE = '0;
      ForwardBE = '0;
   end

   logic unused_nofwd;
   assign unused_nofwd = ^{RA1E, RA2E, WA3W, RegWriteW, MemtoRegE};
`endif

   // ------------------------------------------------------------------
   // Control FSM: next state and stall/flush outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      if (rst) begin
         case (state)
            RUN: begin
               // Start and done together is a single-cycle op: stay in RUN.
               if (mc_startE && !mc_done)
                  state_nxt = MCBUSY;
               if (PCSrcE) begin
                  FlushD = 1'b1;
                  FlushE = 1'b1;
               end else if (raw_hazard) begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  FlushE = 1'b1;
               end
            end
            MCBUSY: begin
               // Stalls drop in the done cycle so the pipeline advances on
               // that same edge; branches are not acted on while busy.
               if (mc_done) begin
                  state_nxt = RUN;
               end else begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  StallE = 1'b1;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // State register and saturating stall counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= RUN;
         stall_cycles <= '0;
      end else begin
         state <= state_nxt;
         if (StallF && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 16'd1;
      end
   end

endmodule
